// File: rtl/fft_out_serializer.sv
// Output stage of the FFT core: captures one parallel frame and streams it out
// one complex sample per beat with sop/eop framing and optional 1/N scaling.
module fft_out_serializer #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inv,
    input  logic [N*DW-1:0] y_par_re,
    input  logic [N*DW-1:0] y_par_im,
    output logic            load_ready,
    input  logic            ready_out,
    output logic            valid_out,
    output logic            sop_out,
    output logic            eop_out,
    output logic [DW-1:0]   y_re,
    output logic [DW-1:0]   y_im,
    output logic            overrun_err
);

    // state  | meaning
    // IDLE   | no frame held, waiting for load
    // STREAM | presenting bank[index] on y_re/y_im, valid_out=1
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t          state;
    logic [AW-1:0]   index;
    logic [AW-1:0]   index_nxt;
    logic            inv_q;
    logic [N*DW-1:0] bank_re;
    logic [N*DW-1:0] bank_im;
    logic            last_beat;
    logic            accept;

    // Divide by N with round-half-up; one guard bit keeps the bias add from wrapping.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input logic en);
        logic signed [DW:0] t;
        logic signed [DW:0] sh;
        t  = $signed({s[DW-1], s}) + $signed((DW+1)'(2 ** (AW - 1)));
        sh = t >>> AW;
        return en ? sh[DW-1:0] : s;
    endfunction

    always_comb begin
        last_beat  = valid_out & ready_out & (index == LAST);
        load_ready = (state == IDLE) | last_beat;
        accept     = load & load_ready;
        index_nxt  = index + AW'(1);
    end

    // Capture bank carries no reset; its contents are only read after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_re <= y_par_re;
            bank_im <= y_par_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            index       <= '0;
            inv_q       <= 1'b0;
            overrun_err <= 1'b0;
            valid_out   <= 1'b0;
            sop_out     <= 1'b0;
            eop_out     <= 1'b0;
            y_re        <= '0;
            y_im        <= '0;
        end else begin
            if (load && !load_ready)
                overrun_err <= 1'b1;

            if (accept) begin
                // Sample 0 comes straight from the inputs since the bank updates on this same edge.
                state     <= STREAM;
                index     <= '0;
                inv_q     <= inv;
                valid_out <= 1'b1;
                sop_out   <= 1'b1;
                eop_out   <= (N == 1);
                y_re      <= scale(y_par_re[DW-1:0], inv);
                y_im      <= scale(y_par_im[DW-1:0], inv);
            end else begin
                case (state)
                    IDLE: begin
                        valid_out <= 1'b0;
                        sop_out   <= 1'b0;
                        eop_out   <= 1'b0;
                    end
                    STREAM: begin
                        if (ready_out) begin
                            if (index == LAST) begin
                                state     <= IDLE;
                                index     <= '0;
                                valid_out <= 1'b0;
                                sop_out   <= 1'b0;
                                eop_out   <= 1'b0;
                                y_re      <= '0;
                                y_im      <= '0;
                            end else begin
                                index   <= index_nxt;
                                sop_out <= 1'b0;
                                eop_out <= (index_nxt == LAST);
                                y_re    <= scale(bank_re[index_nxt*DW +: DW], inv_q);
                                y_im    <= scale(bank_im[index_nxt*DW +: DW], inv_q);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: ramp, backpressure, inverse scaling,
// overrun, back-to-back frames and mid-stream reset.
module tb_fft_out_serializer;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            load = 1'b0;
    logic            inv = 1'b0;
    logic [N*DW-1:0] y_par_re = '0;
    logic [N*DW-1:0] y_par_im = '0;
    logic            load_ready;
    logic            ready_out = 1'b1;
    logic            valid_out;
    logic            sop_out;
    logic            eop_out;
    logic [DW-1:0]   y_re;
    logic [DW-1:0]   y_im;
    logic            overrun_err;

    int n_vec = 0;
    int n_err = 0;

    fft_out_serializer #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .inv         (inv),
        .y_par_re    (y_par_re),
        .y_par_im    (y_par_im),
        .load_ready  (load_ready),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .sop_out     (sop_out),
        .eop_out     (eop_out),
        .y_re        (y_re),
        .y_im        (y_im),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic v, input logic s, input logic e,
                                         input logic [15:0] re, input logic [15:0] im);
        return {29'd0, v, s, e, re, im};
    endfunction

    function automatic logic [63:0] seen();
        return {29'd0, valid_out, sop_out, eop_out, y_re, y_im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: ramp re=k im=-k, 1: alternate frame re=k+1000 im=3k, 2: filler 0x5555
    task automatic set_frame(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       begin y_par_re[k*DW +: DW] = 16'(k);        y_par_im[k*DW +: DW] = 16'(0 - k); end
                1:       begin y_par_re[k*DW +: DW] = 16'(k + 1000); y_par_im[k*DW +: DW] = 16'(3 * k); end
                default: begin y_par_re[k*DW +: DW] = 16'h5555;      y_par_im[k*DW +: DW] = 16'h5555;   end
            endcase
        end
    endtask

    task automatic do_load(input logic inv_v);
        inv  = inv_v;
        load = 1'b1;
        tick();
        load = 1'b0;
        inv  = 1'b0;
    endtask

    initial begin
        // reset
        #2 rst_n = 1'b0;
        #2;
        check("rst_beat", seen(), beat(0, 0, 0, 16'h0, 16'h0));
        check("rst_overrun", {63'd0, overrun_err}, 64'd0);
        check("rst_load_ready", {63'd0, load_ready}, 64'd1);
        #10 rst_n = 1'b1;
        tick();

        // T1 ramp, ready always high
        set_frame(0);
        ready_out = 1'b1;
        do_load(1'b0);
        for (int k = 0; k < N; k++) begin
            check("t1_beat", seen(), beat(1, k == 0, k == N - 1, 16'(k), 16'(0 - k)));
            tick();
        end
        check("t1_idle_after", {63'd0, valid_out}, 64'd0);

        // T2 ready toggles; sample s accepted on cycle 2s, held on odd cycles
        do_load(1'b0);
        for (int c = 0; c < 2 * N - 1; c++) begin
            int s;
            s = (c + 1) / 2;
            ready_out = (c % 2 == 0);
            #1;
            check("t2_beat", seen(), beat(1, s == 0, s == N - 1, 16'(s), 16'(0 - s)));
            tick();
        end
        ready_out = 1'b1;
        check("t2_idle_after_511", {63'd0, valid_out}, 64'd0);

        // T3 inverse scaling
        y_par_re = '0;
        y_par_im = '0;
        y_par_re[0*DW +: DW] = 16'h7FFF;
        y_par_re[1*DW +: DW] = 16'hFF7F;
        y_par_re[2*DW +: DW] = 16'h0080;
        y_par_re[3*DW +: DW] = 16'h007F;
        do_load(1'b1);
        check("t3_s0", seen(), beat(1, 1, 0, 16'h0080, 16'h0000)); tick();
        check("t3_s1", seen(), beat(1, 0, 0, 16'hFFFF, 16'h0000)); tick();
        check("t3_s2", seen(), beat(1, 0, 0, 16'h0001, 16'h0000)); tick();
        check("t3_s3", seen(), beat(1, 0, 0, 16'h0000, 16'h0000)); tick();
        for (int k = 4; k < N; k++) tick();
        check("t3_idle_after", {63'd0, valid_out}, 64'd0);
        check("t3_no_overrun", {63'd0, overrun_err}, 64'd0);

        // T4 overrun load at beat 100 is ignored
        set_frame(0);
        do_load(1'b0);
        for (int k = 0; k < N; k++) begin
            if (k == 100) begin
                check("t4_load_ready_low", {63'd0, load_ready}, 64'd0);
                set_frame(2);
                load = 1'b1;
            end
            check("t4_beat", seen(), beat(1, k == 0, k == N - 1, 16'(k), 16'(0 - k)));
            tick();
            load = 1'b0;
            if (k == 100) check("t4_overrun_set", {63'd0, overrun_err}, 64'd1);
        end
        check("t4_idle_after", {63'd0, valid_out}, 64'd0);
        check("t4_overrun_sticky", {63'd0, overrun_err}, 64'd1);

        // T5 back-to-back frames: new load on the accepted eop beat
        set_frame(0);
        do_load(1'b0);
        for (int k = 0; k < N - 1; k++) tick();
        check("t5_eop_beat", seen(), beat(1, 0, 1, 16'd255, 16'(0 - 255)));
        set_frame(1);
        load = 1'b1;
        #1;
        check("t5_load_ready_eop", {63'd0, load_ready}, 64'd1);
        tick();
        load = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("t5_frame_b", seen(), beat(1, k == 0, k == N - 1, 16'(k + 1000), 16'(3 * k)));
            tick();
        end
        check("t5_idle_after", {63'd0, valid_out}, 64'd0);
        check("t5_overrun_still", {63'd0, overrun_err}, 64'd1);

        // T6 reset mid-stream
        set_frame(0);
        do_load(1'b0);
        for (int k = 0; k < 100; k++) tick();
        check("t6_beat100", seen(), beat(1, 0, 0, 16'd100, 16'(0 - 100)));
        rst_n = 1'b0;
        #1;
        check("t6_rst_beat", seen(), beat(0, 0, 0, 16'h0, 16'h0));
        check("t6_rst_overrun", {63'd0, overrun_err}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("t6_load_ready", {63'd0, load_ready}, 64'd1);
        set_frame(1);
        do_load(1'b0);
        for (int k = 0; k < N; k++) begin
            check("t6_new_frame", seen(), beat(1, k == 0, k == N - 1, 16'(k + 1000), 16'(3 * k)));
            tick();
        end
        check("t6_idle_after", {63'd0, valid_out}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
